instr_controller: RTL

- Instruction register, decoder and sequencing FSM for the Simple RISC Machine; it is the control side that drives the datapath control inputs.
- It latches a 16-bit instruction, decodes its register, immediate and shift fields, and steps the datapath through read, ALU and write-back cycles.
- It reports idle/busy to the surrounding system on `w`, using a start/wait handshake.

---
 rtl/instr_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/instr_controller.sv
// -----------------------------------------------------------------------------
// instr_controller
// Instruction register, field decoder and sequencing FSM for the Simple RISC
// Machine. It holds one 16-bit instruction and steps the datapath through
// read, ALU and write-back cycles, one control word per state.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in[15:0], load      instruction word and its capture strobe (WAIT only)
//   s                   start execution of the instruction held in IR
//   w                   1 = idle in WAIT
//   readnum, writenum   register file read / write indices
//   write               register file write enable
//   loada/loadb/loadc   pipeline register enables
//   loads               status register enable
//   asel, bsel          ALU operand selects
//   vsel, shift, ALUop  write-back select, shifter control, ALU operation
//   sximm5, sximm8      sign-extended immediates from IR
//
// Handshake: w=1 means the controller sits in WAIT and samples load/s on every
// rising edge. load=1 captures `in`; s=1 launches the instruction in IR (the
// freshly loaded word if load and s are high on the same edge). While w=0 both
// load and s are ignored. w returns to 1 for at least one cycle between
// consecutive instructions.
// -----------------------------------------------------------------------------
module instr_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_ALU       = 3'd5,
    ST_WRITE_REG = 3'd6
  } state_e;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{w: 1'b1, default: '0};

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;

  // Instruction classes, evaluated on any IR value.
  function automatic logic is_mov_imm(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
  endfunction

  function automatic logic is_mov_reg(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
  endfunction

  function automatic logic is_alu_op(input logic [15:0] ir);
    return ir[15:13] == 3'b101;
  endfunction

  // Next state and next IR.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_WAIT: begin
        if (load) ir_d = in;
        if (s) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_mov_imm(ir_q))                                state_d = ST_WRITE_IMM;
        else if (is_mov_reg(ir_q))                           state_d = ST_GET_B;
        else if (is_alu_op(ir_q) && (ir_q[12:11] == 2'b11))  state_d = ST_GET_B;
        else if (is_alu_op(ir_q))                            state_d = ST_GET_A;
        else                                                 state_d = ST_WAIT;
      end
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_ALU;
      ST_ALU: begin
        // CMP only updates status; everything else writes back through C.
        if (is_alu_op(ir_q) && (ir_q[12:11] == 2'b01)) state_d = ST_WAIT;
        else                                           state_d = ST_WRITE_REG;
      end
      ST_WRITE_REG: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // The control word is decoded from the state being entered and the IR it
  // will hold, then registered, so outputs are a pure function of the current
  // state and IR without any combinational path from the inputs.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_WAIT: ctrl_d.w = 1'b1;
      ST_WRITE_IMM: begin
        ctrl_d.writenum = ir_d[10:8];
        ctrl_d.vsel     = 2'b10;
        ctrl_d.write    = 1'b1;
      end
      ST_GET_A: begin
        ctrl_d.readnum = ir_d[10:8];
        ctrl_d.loada   = 1'b1;
      end
      ST_GET_B: begin
        ctrl_d.readnum = ir_d[2:0];
        ctrl_d.loadb   = 1'b1;
      end
      ST_ALU: begin
        ctrl_d.shift = ir_d[4:3];
        ctrl_d.bsel  = 1'b0;
        if (is_mov_reg(ir_d)) begin
          ctrl_d.asel  = 1'b1;
          ctrl_d.aluop = 2'b00;
          ctrl_d.loadc = 1'b1;
        end else begin
          ctrl_d.asel  = (ir_d[12:11] == 2'b11);
          ctrl_d.aluop = ir_d[12:11];
          ctrl_d.loadc = (ir_d[12:11] != 2'b01);
          ctrl_d.loads = (ir_d[12:11] == 2'b01);
        end
      end
      ST_WRITE_REG: begin
        ctrl_d.writenum = ir_d[7:5];
        ctrl_d.vsel     = 2'b00;
        ctrl_d.write    = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w        = ctrl_q.w;
  assign readnum  = ctrl_q.readnum;
  assign writenum = ctrl_q.writenum;
  assign write    = ctrl_q.write;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign vsel     = ctrl_q.vsel;
  assign shift    = ctrl_q.shift;
  assign ALUop    = ctrl_q.aluop;

  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule
